// File: rtl/aes128_enc_pipe.sv
// aes128_enc_pipe: unrolled AES-128 encrypt pipeline, stall-all valid/ready.
// Define AES_PIPE_KEYREG_EN for a shared key register loaded by key_load.
module aes128_enc_pipe #(
  parameter int ROUNDS_PER_STAGE = 1,
  parameter int TAG_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [0:127] in_data,
  input  logic [0:127] in_key,
  input  logic [TAG_W-1:0] in_tag,
`ifdef AES_PIPE_KEYREG_EN
  input  logic key_load,
`endif
  output logic out_valid,
  input  logic out_ready,
  output logic [0:127] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [$clog2(10/ROUNDS_PER_STAGE+2)-1:0] occ
);
  localparam int S = 10 / ROUNDS_PER_STAGE;
  localparam int OW = $clog2(S + 2);

  localparam logic [2047:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SB[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input int r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 1; i < r; i++) c = xt(c);
    return c;
  endfunction

  function automatic logic [0:127] knext(
    input logic [0:127] k,
    input logic [7:0] rc
  );
    logic [0:31] t;
    logic [0:127] n;
    t = {sbox(k[104+:8]) ^ rc, sbox(k[112+:8]),
         sbox(k[120+:8]), sbox(k[96+:8])};
    n[0+:32] = k[0+:32] ^ t;
    n[32+:32] = k[32+:32] ^ n[0+:32];
    n[64+:32] = k[64+:32] ^ n[32+:32];
    n[96+:32] = k[96+:32] ^ n[64+:32];
    return n;
  endfunction

  function automatic logic [0:127] rnd(
    input logic [0:127] s,
    input logic [0:127] rk,
    input logic last
  );
    logic [7:0] b [16];
    logic [7:0] h [16];
    logic [7:0] a0, a1, a2, a3;
    logic [0:127] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[8*i+:8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        h[4*c+r] = b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = h[4*c];
      a1 = h[4*c+1];
      a2 = h[4*c+2];
      a3 = h[4*c+3];
      if (last) o[32*c+:32] = {a0, a1, a2, a3};
      else o[32*c+:32] = {
        xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
        xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o ^ rk;
  endfunction

  logic [S:0] v_q;
  logic [0:127] st_q [S+1];
  logic [0:127] st_d [S+1];
  logic [0:127] rk_q [S+1];
  logic [0:127] rk_d [S+1];
  logic [TAG_W-1:0] tg_q [S+1];
  logic [OW-1:0] occ_q, occ_d;
  logic [0:127] key_c;
  logic en, in_fire, out_fire;

  assign en = !v_q[S] || out_ready;
  assign in_fire = in_valid && in_ready;
  assign out_fire = v_q[S] && out_ready;

`ifdef AES_PIPE_KEYREG_EN
  logic [0:127] key_q;

  // Key register loads only once the pipeline is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) key_q <= '0;
    else if (key_load && occ_q == '0) key_q <= in_key;
  end

  assign key_c = key_q;
  assign in_ready = en && !key_load;
`else
  assign key_c = in_key;
  assign in_ready = en;
`endif

  // Stage 0 whitens; stages 1..S each run their slice of rounds.
  always_comb begin
    logic [0:127] s, k;
    int rn;
    st_d[0] = in_data ^ key_c;
    rk_d[0] = key_c;
    for (int j = 1; j <= S; j++) begin
      s = st_q[j-1];
      k = rk_q[j-1];
      for (int r = 0; r < ROUNDS_PER_STAGE; r++) begin
        rn = (j-1)*ROUNDS_PER_STAGE + r + 1;
        k = knext(k, rcon(rn));
        s = rnd(s, k, rn == 10);
      end
      st_d[j] = s;
      rk_d[j] = k;
    end
  end

  // Every stage advances together, bubbles included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      for (int j = 0; j <= S; j++) begin
        st_q[j] <= '0;
        rk_q[j] <= '0;
        tg_q[j] <= '0;
      end
    end else if (en) begin
      v_q <= {v_q[S-1:0], in_fire};
      st_q <= st_d;
      rk_q <= rk_d;
      tg_q[0] <= in_tag;
      for (int j = 1; j <= S; j++) tg_q[j] <= tg_q[j-1];
    end
  end

  // In-flight count; simultaneous in and out cancel.
  always_comb begin
    occ_d = occ_q;
    unique case ({in_fire, out_fire})
      2'b10: occ_d = occ_q + OW'(1);
      2'b01: occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) occ_q <= '0;
    else occ_q <= occ_d;
  end

  assign out_valid = v_q[S];
  assign out_data = st_q[S];
  assign out_tag = tg_q[S];
  assign occ = occ_q;
endmodule

// File: tb/tb_aes128_enc_pipe.sv
// tb_aes128_enc_pipe: FIPS-197 vectors through four pipeline depths
// sharing one stimulus, each with its own in-order scoreboard.
module tb_aes128_enc_pipe;
  localparam int N = 4;
`ifdef AES_PIPE_KEYREG_EN
  localparam bit KR = 1'b1;
`else
  localparam bit KR = 1'b0;
`endif

  typedef struct {
    logic [0:127] key;
    logic [0:127] pt;
    logic [0:127] ct;
    int tag;
  } vec_t;
  vec_t vt [2];

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [0:127] in_data, in_key;
  logic [3:0] in_tag;
  logic out_ready [N];
`ifdef AES_PIPE_KEYREG_EN
  logic key_load;
`endif
  wire in_ready [N];
  wire out_valid [N];
  wire [0:127] out_data [N];
  wire [3:0] out_tag [N];
  wire [3:0] occ [N];

  int lat_exp [N] = '{11, 6, 3, 2};
  int sb_v [N][64];
  int sb_t [N][64];
  int wr [N];
  int rd [N];
  int nout [N];
  int cur_v;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int R = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    logic [$clog2(10/R+2)-1:0] oc;
    aes128_enc_pipe #(.ROUNDS_PER_STAGE(R), .TAG_W(4)) u_dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready[g]),
      .in_data(in_data),
      .in_key(in_key),
      .in_tag(in_tag),
`ifdef AES_PIPE_KEYREG_EN
      .key_load(key_load),
`endif
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data(out_data[g]),
      .out_tag(out_tag[g]),
      .occ(oc)
    );
    assign occ[g] = 4'(oc);
  end

  task automatic check(input string nm, input int g,
                       input logic [0:127] act, input logic [0:127] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, g, act, exp);
    end
  endtask

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int g = 0; g < N; g++) begin
        wr[g] = 0;
        rd[g] = 0;
      end
    end else begin
      for (int g = 0; g < N; g++) begin
        logic er;
        er = !out_valid[g] || out_ready[g];
`ifdef AES_PIPE_KEYREG_EN
        er = er && !key_load;
`endif
        check("in_ready", g, 128'(in_ready[g]), 128'(er));
        if (wr[g] == rd[g]) begin
          check("unexpected_out", g, 128'(out_valid[g]), 128'(0));
        end else if (out_valid[g]) begin
          check("out_data", g, out_data[g], vt[sb_v[g][rd[g]%64]].ct);
          check("out_tag", g, 128'(out_tag[g]), 128'(sb_t[g][rd[g]%64]));
          if (out_ready[g]) begin
            rd[g]++;
            nout[g]++;
          end
        end
        if (in_valid && er) begin
          sb_v[g][wr[g]%64] = cur_v;
          sb_t[g][wr[g]%64] = int'(in_tag);
          wr[g]++;
        end
      end
    end
  end

  task automatic send(input int v, input int t);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data = vt[v].pt;
    in_key = vt[v].key;
    in_tag = 4'(t);
    cur_v = v;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(negedge clk);
    for (int g = 0; g < N; g++)
      check("pending", g, 128'(wr[g] - rd[g]), 128'(0));
  endtask

  task automatic load_key(input int v);
`ifdef AES_PIPE_KEYREG_EN
    int k;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    key_load = 1'b1;
    in_key = vt[v].key;
    k = 0;
    @(negedge clk);
    while (k < 40 && (occ[0] | occ[1] | occ[2] | occ[3]) != 4'd0) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    key_load = 1'b0;
`else
    cur_v = cur_v + 0 * v;
`endif
  endtask

  initial begin
    int first [N];
    int snap [N];
    vt[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32, 5};
    vt[1] = '{128'h000102030405060708090a0b0c0d0e0f,
              128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10};
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_key = '0;
    in_tag = '0;
    cur_v = 0;
    for (int g = 0; g < N; g++) begin
      out_ready[g] = 1'b1;
      nout[g] = 0;
    end
`ifdef AES_PIPE_KEYREG_EN
    key_load = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 0, 128'(in_ready[0]), 128'(1));
    check("rst_out_data", 0, out_data[0], 128'(0));
    check("rst_out_tag", 0, 128'(out_tag[0]), 128'(0));
    for (int g = 0; g < N; g++) begin
      check("rst_out_valid", g, 128'(out_valid[g]), 128'(0));
      check("rst_occ", g, 128'(occ[g]), 128'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int v = 0; v < 2; v++) begin
      load_key(v);
      send(v, vt[v].tag);
      idle();
      for (int g = 0; g < N; g++) first[g] = -1;
      for (int k = 1; k <= 14; k++) begin
        @(negedge clk);
        if (k == 1) check("occ_after_in", 0, 128'(occ[0]), 128'(1));
        if (k == 11) check("occ_at_out", 0, 128'(occ[0]), 128'(1));
        if (k == 12) check("occ_after_out", 0, 128'(occ[0]), 128'(0));
        for (int g = 0; g < N; g++)
          if (out_valid[g] && first[g] < 0) first[g] = k;
      end
      for (int g = 0; g < N; g++)
        check("latency", g, 128'(first[g]), 128'(lat_exp[g]));
    end

    load_key(0);
    for (int i = 0; i < 20; i++) begin
      send(KR ? 0 : i % 2, i);
      if (i == 14) for (int g = 0; g < N; g++) snap[g] = nout[g];
      if (i == 19)
        for (int g = 0; g < N; g++)
          check("throughput", g, 128'(nout[g] - snap[g]), 128'(5));
    end
    idle();
    drain(16);

    for (int i = 0; i < 30; i++) begin
      send(KR ? 0 : i % 2, i);
      if (i == 15) out_ready[0] = 1'b0;
      if (i == 23) out_ready[0] = 1'b1;
      if (i == 22) begin
        @(negedge clk);
        check("bp_occ_full", 0, 128'(occ[0]), 128'(11));
        check("bp_in_ready", 0, 128'(in_ready[0]), 128'(0));
        check("bp_out_valid", 0, 128'(out_valid[0]), 128'(1));
      end
    end
    idle();
    drain(20);

    for (int i = 0; i < 7; i++) send(KR ? 0 : i % 2, i + 3);
    idle();
    @(negedge clk);
    check("pre_rst_occ", 0, 128'(occ[0]), 128'(7));
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", 0, 128'(out_valid[0]), 128'(0));
    check("arst_occ", 0, 128'(occ[0]), 128'(0));
    check("arst_out_data", 0, out_data[0], 128'(0));
    check("arst_out_tag", 0, 128'(out_tag[0]), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 0, 128'(in_ready[0]), 128'(1));
    drain(20);
    load_key(1);
    send(1, 9);
    idle();
    drain(16);

`ifdef AES_PIPE_KEYREG_EN
    load_key(0);
    for (int i = 0; i < 3; i++) send(0, i);
    @(posedge clk);
    #1;
    key_load = 1'b1;
    in_key = vt[1].key;
    in_data = vt[1].pt;
    in_tag = 4'd7;
    cur_v = 1;
    @(negedge clk);
    check("kl_occ3", 0, 128'(occ[0]), 128'(3));
    for (int k = 0; k < 40 && occ[0] != 4'd0; k++) @(negedge clk);
    check("kl_drained", 0, 128'(occ[0]), 128'(0));
    @(posedge clk);
    #1;
    key_load = 1'b0;
    idle();
    drain(16);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
